// File: rtl/ram_arb_pkg.sv
// Shared definitions for the program-RAM port arbiter: FSM states, requester ids
// and the default RAM geometry also used by the boot loader and the core.
package ram_arb_pkg;

    localparam int ADR_W_DEF = 6;
    localparam int DAT_W_DEF = 16;

    localparam logic REQ_LD = 1'b0;
    localparam logic REQ_CO = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } arb_state_e;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between loader and core.
// Build option: RAM_ARB_RR_EN selects round-robin on ties, otherwise loader has fixed priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic [1:0] i_elig,
    input  logic       i_last,
    output logic       o_winner,
    output logic       o_valid
);

`ifdef RAM_ARB_RR_EN
    // On a tie the requester that did not win last time goes first
    always_comb begin
        o_valid = |i_elig;
        if (i_elig == 2'b11) begin
            o_winner = ~i_last;
        end else if (i_elig[REQ_LD]) begin
            o_winner = REQ_LD;
        end else begin
            o_winner = REQ_CO;
        end
    end
`else
    logic w_unused;
    assign w_unused = i_last;

    // Loader always beats the core
    always_comb begin
        o_valid = |i_elig;
        if (i_elig[REQ_LD]) begin
            o_winner = REQ_LD;
        end else begin
            o_winner = REQ_CO;
        end
    end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port program RAM between boot loader and core; all outputs registered.
// Build option: RAM_ARB_RR_EN enables round-robin tie breaking (last-winner register).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int DAT_W  = DAT_W_DEF,
    parameter int RD_LAT = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             boot,
    input  logic             ld_req,
    input  logic             ld_we,
    input  logic [ADR_W-1:0] ld_adr,
    input  logic [DAT_W-1:0] ld_wdata,
    output logic             ld_gnt,
    output logic             ld_rvalid,
    output logic [DAT_W-1:0] ld_rdata,
    input  logic             co_req,
    input  logic             co_we,
    input  logic [ADR_W-1:0] co_adr,
    input  logic [DAT_W-1:0] co_wdata,
    output logic             co_gnt,
    output logic             co_rvalid,
    output logic [DAT_W-1:0] co_rdata,
    output logic             ram_enable,
    output logic             ram_rw,
    output logic [ADR_W-1:0] ram_adr,
    output logic [DAT_W-1:0] ram_in,
    input  logic [DAT_W-1:0] ram_out
);

    localparam logic [1:0] LAT = RD_LAT[1:0];

    arb_state_e       r_state, w_state_nxt;
    logic [1:0]       r_cnt;
    logic             r_we, r_id;
    logic [1:0]       r_gnt, r_rvalid;
    logic [DAT_W-1:0] r_rdata_ld, r_rdata_co;

    logic [1:0]       w_elig;
    logic             w_win, w_win_vld, w_last;
    logic             w_win_we;
    logic [ADR_W-1:0] w_win_adr;
    logic [DAT_W-1:0] w_win_wdata;

    logic             w_ram_enable, w_ram_rw;
    logic [ADR_W-1:0] w_ram_adr;
    logic [DAT_W-1:0] w_ram_in, w_rdata_ld, w_rdata_co;
    logic [1:0]       w_gnt, w_rvalid;

    assign w_elig = {co_req & ~boot, ld_req};

    ram_arb_pick u_pick (
        .i_elig   (w_elig),
        .i_last   (w_last),
        .o_winner (w_win),
        .o_valid  (w_win_vld)
    );

`ifdef RAM_ARB_RR_EN
    logic r_last;

    // Remember who went last so ties alternate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= REQ_CO;
        end else if (ce && (r_state == ST_ISSUE)) begin
            r_last <= r_id;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = REQ_CO;
`endif

    assign w_win_we    = (w_win == REQ_CO) ? co_we    : ld_we;
    assign w_win_adr   = (w_win == REQ_CO) ? co_adr   : ld_adr;
    assign w_win_wdata = (w_win == REQ_CO) ? co_wdata : ld_wdata;

    // State register plus the latched winner and read-latency counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 2'd0;
            r_we    <= 1'b0;
            r_id    <= REQ_LD;
        end else if (ce) begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_win_vld) begin
                r_we <= w_win_we;
                r_id <= w_win;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= LAT;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   w_state_nxt = w_win_vld ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:  w_state_nxt = r_we ? ST_IDLE : ST_WAIT;
            ST_WAIT:   w_state_nxt = (r_cnt <= 2'd1) ? ST_RETURN : ST_WAIT;
            ST_RETURN: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; command and gnt land in the ISSUE cycle
    always_comb begin
        w_ram_enable = 1'b0;
        w_ram_rw     = ram_rw;
        w_ram_adr    = ram_adr;
        w_ram_in     = ram_in;
        w_gnt        = 2'b00;
        w_rvalid     = 2'b00;
        w_rdata_ld   = r_rdata_ld;
        w_rdata_co   = r_rdata_co;
        case (r_state)
            ST_IDLE: begin
                if (w_win_vld) begin
                    w_ram_enable = 1'b1;
                    w_ram_rw     = w_win_we;
                    w_ram_adr    = w_win_adr;
                    w_ram_in     = w_win_wdata;
                    w_gnt[w_win] = 1'b1;
                end else begin
                    w_ram_enable = 1'b0;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 2'd1) begin
                    w_rvalid[r_id] = 1'b1;
                    if (r_id == REQ_CO) begin
                        w_rdata_co = ram_out;
                    end else begin
                        w_rdata_ld = ram_out;
                    end
                end else begin
                    w_rvalid = 2'b00;
                end
            end
            default: w_ram_enable = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_enable <= 1'b0;
            ram_rw     <= 1'b0;
            ram_adr    <= {ADR_W{1'b0}};
            ram_in     <= {DAT_W{1'b0}};
            r_gnt      <= 2'b00;
            r_rvalid   <= 2'b00;
            r_rdata_ld <= {DAT_W{1'b0}};
            r_rdata_co <= {DAT_W{1'b0}};
        end else if (ce) begin
            ram_enable <= w_ram_enable;
            ram_rw     <= w_ram_rw;
            ram_adr    <= w_ram_adr;
            ram_in     <= w_ram_in;
            r_gnt      <= w_gnt;
            r_rvalid   <= w_rvalid;
            r_rdata_ld <= w_rdata_ld;
            r_rdata_co <= w_rdata_co;
        end
    end

    assign ld_gnt    = r_gnt[REQ_LD];
    assign co_gnt    = r_gnt[REQ_CO];
    assign ld_rvalid = r_rvalid[REQ_LD];
    assign co_rvalid = r_rvalid[REQ_CO];
    assign ld_rdata  = r_rdata_ld;
    assign co_rdata  = r_rdata_co;

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and access sequencer for the single-port 64×16 program RAM. It shares the RAM between the UART boot loader (`ld_*`) and the processing core (`co_*`), and drives `ram_enable`, `ram_rw`, `ram_adr` and `ram_in`. It registers `ram_out` back to whichever requester issued the read. It sits between the boot loader, the core and the RAM macro inside the top-level wrapper.

## Interface
- `ADR_W`, 6: RAM address width.
- `DAT_W`, 16: RAM data width.
- `RD_LAT`, 1: RAM read latency in cycles, from the command-sampling edge to valid `ram_out`. Range 1–3.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ce` in 1: clock enable. When 0, all state and outputs hold.
- `boot` in 1: boot mode. While 1, core requests are masked at arbitration.
- `ld_req`, `ld_we` in 1 each: loader request; `ld_we` = 1 for write, 0 for read.
- `ld_adr` in ADR_W, `ld_wdata` in DAT_W: loader command.
- `ld_gnt` out 1: one-cycle pulse marking the cycle the loader command is on the RAM port.
- `ld_rvalid` out 1, `ld_rdata` out DAT_W: loader read return.
- `co_req`, `co_we`, `co_adr`, `co_wdata`, `co_gnt`, `co_rvalid`, `co_rdata`: same set for the core.
- `ram_enable` out 1: RAM access strobe.
- `ram_rw` out 1: 1 = write, 0 = read.
- `ram_adr` out ADR_W, `ram_in` out DAT_W: RAM command.
- `ram_out` in DAT_W: RAM read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RETURN.
- **IDLE:** sample requests. The eligible set is `{ld_req, co_req & ~boot}`.
  - If none are eligible, stay in IDLE.
  - Otherwise pick a winner, latch its `we`/`adr`/`wdata` and its id, then go to ISSUE.
- **ISSUE** (exactly 1 cycle):
  - Drive `ram_enable` = 1, `ram_rw` = latched `we`, `ram_adr`/`ram_in` = latched values.
  - Drive the winner's `gnt` = 1.
  - Next state: write → IDLE; read → WAIT, with the counter loaded to `RD_LAT`.
- **WAIT:** count down. At count 1, capture `ram_out` into the winner's `rdata` register and go to RETURN.
- **RETURN** (1 cycle): winner's `rvalid` = 1, then IDLE.
- **Requester rule:** hold `req` and the command stable until `gnt` is seen. In the cycle after `gnt`, the requester either drops `req` or presents the next command. The arbiter ignores `req` in every state except IDLE, so no access is ever issued twice.
- **Registers:** `rdata` registers hold their value until the next read by the same requester. `ram_adr`/`ram_in` hold their last value while `ram_enable` = 0.
- **`boot` changes:** a change takes effect only at IDLE sampling. An access already in flight completes normally.
- **Simultaneous requests, default:** fixed priority, loader wins.
- **Reset:** the asynchronous reset immediately forces IDLE and zeroes every output, including aborting an in-flight access. After reset, the priority pointer favours the loader.

## Timing
- Reset values: `ram_enable`, `ram_rw`, `ram_adr`, `ram_in`, both `gnt`, both `rvalid`, both `rdata` all = 0.
- All outputs are registered. There is no combinational path from a request to any RAM port.
- Write: `req` sampled at edge E0 → command and `gnt` in the following cycle → next sampling at E2. Throughput is one write per 2 cycles.
- Read: `req` at E0 → command in cycle 1 → `ram_out` captured at edge E(1+RD_LAT) → `rvalid` in cycle 2+RD_LAT → IDLE again.
  - With `RD_LAT` = 1, `rvalid` is 3 cycles after the sampling edge, and back-to-back reads run one per 4 cycles.
- `ce` = 0 freezes FSM, counter and outputs in place. A `gnt` or `rvalid` pulse stretches for as long as `ce` stays low.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin arbitration.
  - A one-bit last-winner register is updated at each ISSUE.
  - On a tie, the requester that did not win last wins.
  - The register resets to "core", so the first tie goes to the loader.
- `RAM_ARB_RR_EN` undefined: fixed priority, loader over core. The last-winner register is not built.

## Structure
- **Shared package `ram_arb_pkg`:**
  - FSM state enum (IDLE, ISSUE, WAIT, RETURN).
  - Requester id constants `REQ_LD` = 0, `REQ_CO` = 1.
  - Default `ADR_W`/`DAT_W`, shared with the boot loader and the core.
- **Sub-module `ram_arb_pick`:** combinational winner selection. Inputs are the eligible mask and the last winner; output is the winner id and a valid flag. The round-robin variant lives only here, under `RAM_ARB_RR_EN`.

## Test plan
- Reset mid-read: assert `rst_n` = 0 during WAIT → all outputs 0 that same cycle, no `rvalid` afterwards.
- Loader write `adr` = 0x05, `wdata` = 0xBEEF → `ram_enable` = 1, `ram_rw` = 1, `ram_adr` = 0x05, `ram_in` = 0xBEEF and `ld_gnt` = 1, all for exactly one cycle.
- Core read of 0x05 with `boot` = 0, `RD_LAT` = 1 → `co_rvalid` = 1 with `co_rdata` = 0xBEEF, 3 cycles after the sampling edge.
- `boot` = 1, `co_req` held 10 cycles → no `co_gnt`. Drop `boot` → `co_gnt` at the next IDLE sample plus 1.
- Both `req` high for 4 accesses, macro off → order LD, LD, LD, LD (core starves while loader requests).
- Same stimulus, macro on → grant order LD, CO, LD, CO.
